// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: branch-op bit positions,
// prediction/ok bit order and default widths.
package branch_resolve_unit_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int PC_WIDTH_DEF = 32;
  localparam int BR_W_DEF     = 6;

  // One-hot branch condition bit indices
  localparam int BRANCH_EQ  = 0;
  localparam int BRANCH_NE  = 1;
  localparam int BRANCH_LT  = 2;
  localparam int BRANCH_GE  = 3;
  localparam int BRANCH_LTU = 4;
  localparam int BRANCH_GEU = 5;

  // Bit order of in_pred / trn_ok: {global, local, final}
  localparam int PRED_FINAL  = 0;
  localparam int PRED_LOCAL  = 1;
  localparam int PRED_GLOBAL = 2;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request, redirect and training-record signals of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32,
  parameter int BR_W     = 6
);
  // Handshakes: a transfer happens on a rising clk edge where valid & ready are
  // both high; valid may not depend on ready, and payload is stable while valid.
  logic                in_valid;
  logic                in_ready;
  logic                in_op_branch;
  logic                in_op_jalr;
  logic                in_ecall;
  logic                in_mret;
  logic [BR_W-1:0]     in_br_op;
  logic [XLEN-1:0]     in_rs1;
  logic [XLEN-1:0]     in_rs2;
  logic [XLEN-1:0]     in_csr_data;
  logic [XLEN-1:0]     in_imm;
  logic [PC_WIDTH-1:0] in_pc;
  logic [PC_WIDTH-1:0] in_npc;
  logic [2:0]          in_pred;
  logic                flush;

  logic                redir_valid;
  logic [PC_WIDTH-1:0] redir_pc;
  logic                misalign;

  logic                trn_valid;
  logic                trn_ready;
  logic [PC_WIDTH-1:0] trn_pc;
  logic                trn_taken;
  logic [2:0]          trn_ok;

  modport master (
    output in_valid, in_op_branch, in_op_jalr, in_ecall, in_mret, in_br_op,
           in_rs1, in_rs2, in_csr_data, in_imm, in_pc, in_npc, in_pred, flush,
           trn_ready,
    input  in_ready, redir_valid, redir_pc, misalign,
           trn_valid, trn_pc, trn_taken, trn_ok
  );

  modport slave (
    input  in_valid, in_op_branch, in_op_jalr, in_ecall, in_mret, in_br_op,
           in_rs1, in_rs2, in_csr_data, in_imm, in_pc, in_npc, in_pred, flush,
           trn_ready,
    output in_ready, redir_valid, redir_pc, misalign,
           trn_valid, trn_pc, trn_taken, trn_ok
  );
endinterface

// File: rtl/br_train_fifo.sv
// Synchronous FIFO holding predictor training records; a write while full is
// accepted only together with a read (read-first).
module br_train_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jalr/ecall/mret resolver: redirects fetch on next-PC
// mismatch, queues predictor training records and counts branches/mispredicts.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int BR_W        = BR_W_DEF,
  parameter int TRAIN_DEPTH = 4,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     cnt_branch,
  output logic [CNT_W-1:0]     cnt_mispred
);
  localparam int CW = $clog2(TRAIN_DEPTH) + 1;
  localparam int TW = PC_WIDTH + 4;

  logic                s_valid, s_branch, s_jalr, s_trap;
  logic [BR_W-1:0]     s_br_op;
  logic [XLEN-1:0]     s_rs1, s_rs2, s_csr, s_imm;
  logic [PC_WIDTH-1:0] s_pc, s_npc;
  logic [2:0]          s_pred;

  logic                accept;
  logic [XLEN:0]       sub;
  logic                eq, lt, ltu;
  logic [BR_W-1:0]     cond;
  logic                taken;
  logic [XLEN-1:0]     jalr_sum;
  logic [PC_WIDTH-1:0] actual;
  logic                resolve, redir, fifo_wr;
  logic [2:0]          ok;

  logic [TW-1:0]       head;
  logic                fifo_empty, fifo_full;
  logic [CW-1:0]       fifo_count;

  assign accept = bus.in_valid & bus.in_ready;

  // One free slot is reserved for a branch already sitting in the stage
  assign bus.in_ready = ~bus.flush & ~fifo_full &
                        ~((fifo_count == CW'(TRAIN_DEPTH-1)) & s_valid & s_branch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid  <= 1'b0;
      s_branch <= 1'b0;
      s_jalr   <= 1'b0;
      s_trap   <= 1'b0;
      s_br_op  <= '0;
      s_rs1    <= '0;
      s_rs2    <= '0;
      s_csr    <= '0;
      s_imm    <= '0;
      s_pc     <= '0;
      s_npc    <= '0;
      s_pred   <= '0;
    end else begin
      s_valid <= accept;
      if (accept) begin
        s_branch <= bus.in_op_branch;
        s_jalr   <= bus.in_op_jalr;
        s_trap   <= bus.in_ecall | bus.in_mret;
        s_br_op  <= bus.in_br_op;
        s_rs1    <= bus.in_rs1;
        s_rs2    <= bus.in_rs2;
        s_csr    <= bus.in_csr_data;
        s_imm    <= bus.in_imm;
        s_pc     <= bus.in_pc;
        s_npc    <= bus.in_npc;
        s_pred   <= bus.in_pred;
      end
    end
  end

  // Compare on a single subtractor; carry-out clear means rs1 < rs2 unsigned
  assign sub = {1'b0, s_rs1} + {1'b0, ~s_rs2} + {{XLEN{1'b0}}, 1'b1};
  assign eq  = (sub[XLEN-1:0] == '0);
  assign ltu = ~sub[XLEN];
  assign lt  = (s_rs1[XLEN-1] != s_rs2[XLEN-1]) ? s_rs1[XLEN-1] : sub[XLEN-1];

  always_comb begin
    cond             = '0;
    cond[BRANCH_EQ]  = eq;
    cond[BRANCH_NE]  = ~eq;
    cond[BRANCH_LT]  = lt;
    cond[BRANCH_GE]  = ~lt;
    cond[BRANCH_LTU] = ltu;
    cond[BRANCH_GEU] = ~ltu;
  end

  assign taken    = |(s_br_op & cond);
  assign jalr_sum = s_rs1 + s_imm;

  always_comb begin
    actual = s_npc;
    if (s_trap)        actual = s_csr[PC_WIDTH-1:0];
    else if (s_jalr)   actual = jalr_sum[PC_WIDTH-1:0] & ~PC_WIDTH'(1);
    else if (s_branch) actual = taken ? s_pc + s_imm[PC_WIDTH-1:0]
                                      : s_pc + PC_WIDTH'(4);
  end

  assign resolve = s_valid & ~bus.flush;
  assign redir   = resolve & (s_trap | (actual != s_npc));
  assign fifo_wr = resolve & s_branch;

  assign bus.redir_valid = redir;
  assign bus.redir_pc    = redir ? actual : '0;
  assign bus.misalign    = redir & actual[1] & ~s_trap;

  always_comb begin
    ok              = '0;
    ok[PRED_GLOBAL] = (s_pred[PRED_GLOBAL] == taken);
    ok[PRED_LOCAL]  = (s_pred[PRED_LOCAL]  == taken);
    ok[PRED_FINAL]  = (s_pred[PRED_FINAL]  == taken);
  end

  br_train_fifo #(.DEPTH(TRAIN_DEPTH), .W(TW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({s_pc, taken, ok}),
    .rd_en   (bus.trn_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Head fields are masked so an empty FIFO presents all zeros
  assign bus.trn_valid = ~fifo_empty;
  assign bus.trn_pc    = fifo_empty ? '0   : head[TW-1:4];
  assign bus.trn_taken = fifo_empty ? 1'b0 : head[3];
  assign bus.trn_ok    = fifo_empty ? '0   : head[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else begin
      if (fifo_wr && (cnt_branch != '1))
        cnt_branch <= cnt_branch + 1'b1;
      if (redir && !s_trap && (cnt_mispred != '1))
        cnt_mispred <= cnt_mispred + 1'b1;
    end
  end
endmodule
